// File: rtl/pwm_from_count_if.sv
// Duty-update handshake between a duty source and the PWM compare stage.
interface pwm_from_count_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/pwm_from_count.sv
// PWM compare stage fed by a free-running up-counter. Duty updates go through
// a one-deep shadow slot applied only at the period boundary; a small FSM
// selects continuous or one-shot operation.
module pwm_from_count #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             en,
    input  logic             oneshot,
    pwm_from_count_if.slave  duty,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             mode_os;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] pending;
    logic             pending_vld;
    logic             bnd;
    logic             pwm_d;
    logic             period_done_d;

    // Last count of the period; purely value-based.
    assign bnd = (cnt_in == '1);

    // Ready comes straight from the slot flag, never from duty_valid.
    assign duty.duty_ready = ~pending_vld;

    // Shadow slot: pending applies at the boundary; an offer landing on the
    // boundary itself bypasses the slot (slot is empty, so ready is high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty <= RESET_DUTY;
            pending     <= '0;
            pending_vld <= 1'b0;
        end else if (bnd) begin
            if (pending_vld) begin
                active_duty <= pending;
                pending_vld <= 1'b0;
            end else if (duty.duty_valid) begin
                active_duty <= duty.duty_in;
            end
        end else if (duty.duty_valid && !pending_vld) begin
            pending     <= duty.duty_in;
            pending_vld <= 1'b1;
        end
    end

    // State register, one-shot mode latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_os     <= 1'b0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwm_out     <= pwm_d;
            period_done <= period_done_d;
            if (state_q == IDLE && en) begin
                mode_os <= oneshot;
            end
        end
    end

    // Next-state logic; dropping en always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (en) state_d = ARMED;
            ARMED: begin
                if (!en)      state_d = IDLE;
                else if (bnd) state_d = RUN;
            end
            RUN: begin
                if (!en)                 state_d = IDLE;
                else if (bnd && mode_os) state_d = DONE;
            end
            DONE:  if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; gating with en makes an abort silence pwm_out and
    // suppress period_done on the very next cycle.
    always_comb begin
        pwm_d         = (state_q == RUN) && en && (cnt_in < active_duty);
        period_done_d = (state_q == RUN) && en && bnd;
        busy          = (state_q == ARMED) || (state_q == RUN);
    end

endmodule
